// File: rtl/module_division.sv
// module_division: 4-bit restoring divider, one quotient bit per clock, MSB first.
// Define DIV_ZERO_CHECK_EN to short-circuit B=0 to DONE with err=1.
module module_division (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Q,
  output logic [3:0] Rem,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t     state_q;
  logic [4:0] p_q;
  logic [3:0] aq_q;
  logic [3:0] bq_q;
  logic [3:0] qr_q;
  logic [1:0] k_q;
  logic [3:0] q_q;
  logic [3:0] rem_q;
  logic       busy_q;
  logic       done_q;

  logic [5:0] s_w;
  logic [5:0] diff_w;
  logic       borrow_w;

  // P never exceeds Bq-1, so the top shift bit is always zero
  always_comb begin
    s_w      = {p_q, aq_q[k_q]};
    diff_w   = s_w - {2'b00, bq_q};
    borrow_w = diff_w[5];
  end

`ifdef DIV_ZERO_CHECK_EN
  logic err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      aq_q    <= '0;
      bq_q    <= '0;
      qr_q    <= '0;
      k_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            aq_q   <= A;
            bq_q   <= B;
            p_q    <= '0;
            qr_q   <= '0;
            k_q    <= 2'd3;
            busy_q <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            if (B == 4'd0) begin
              p_q     <= {1'b0, A};
              qr_q    <= 4'hF;
              state_q <= DONE;
            end else begin
              err_q   <= 1'b0;
              state_q <= ITER;
            end
`else
            state_q <= ITER;
`endif
          end
        end
        ITER: begin
          if (borrow_w) begin
            p_q <= s_w[4:0];
          end else begin
            p_q       <= diff_w[4:0];
            qr_q[k_q] <= 1'b1;
          end
          k_q <= k_q - 2'd1;
          if (k_q == 2'd0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          q_q     <= qr_q;
          rem_q   <= p_q[3:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef DIV_ZERO_CHECK_EN
          err_q   <= (bq_q == 4'd0);
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign Rem  = rem_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef DIV_ZERO_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_module_division.sv
// tb_module_division: directed vectors plus an arithmetic reference model
// compared against the divider outputs on every falling edge.
module tb_module_division;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] Rem;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  module_division dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .Rem  (Rem),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result from plain arithmetic, timing as a cycle countdown
  int mcnt;
  int m_q, m_r, m_err, m_busy, m_done;
  int pq, pr, perr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt = 0; m_q = 0; m_r = 0; m_err = 0; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (mcnt == 0) begin
        if (start) begin
          pq   = (B == 0) ? 15 : int'(A) / int'(B);
          pr   = (B == 0) ? int'(A) : int'(A) % int'(B);
          perr = (CHK && B == 0) ? 1 : 0;
          mcnt = (CHK && B == 0) ? 1 : 5;
          m_busy = 1;
          if (B != 0) m_err = 0;
        end
      end else begin
        mcnt--;
        if (mcnt == 0) begin
          m_done = 1; m_busy = 0;
          m_q = pq; m_r = pr; m_err = perr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("Q", Q, m_q);
      chk("Rem", Rem, m_r);
      chk("err", err, m_err);
    end
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input int eq, input int er, input int ee,
                        input int elat, input string tag);
    int n;
    bit seen;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    chk({tag, " latency"}, seen ? n : -1, elat);
    chk({tag, " Q"}, Q, eq);
    chk({tag, " Rem"}, Rem, er);
    chk({tag, " err"}, err, ee);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, c1, c2;
    logic [3:0] cq, cr;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset Q", Q, 0);
    chk("reset Rem", Rem, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    rst = 1'b0;

    run_op(4'd13, 4'd4, 3, 1, 0, 5, "13/4");
    run_op(4'd15, 4'd1, 15, 0, 0, 5, "15/1");
    run_op(4'd3,  4'd7, 0, 3, 0, 5, "3/7");
    run_op(4'd9,  4'd9, 1, 0, 0, 5, "9/9");
    run_op(4'd7,  4'd0, 15, 7, CHK ? 1 : 0, CHK ? 1 : 5, "7/0");
    run_op(4'd6,  4'd2, 3, 0, 0, 5, "6/2 after zero");

    // start pulses during busy must be ignored
    A = 4'd12; B = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A = 4'd1; B = 4'd1; start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    nd = 0; cq = '0; cr = '0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) begin nd++; cq = Q; cr = Rem; end
    end
    chk("busy-start dones", nd, 1);
    chk("busy-start Q", cq, 2);
    chk("busy-start Rem", cr, 2);

    // start held high runs back-to-back
    A = 4'd13; B = 4'd4; start = 1'b1;
    nd = 0; c1 = -1; c2 = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (c1 < 0) c1 = i; else c2 = i;
      end
    end
    start = 1'b0;
    chk("b2b dones", nd, 2);
    chk("b2b first", c1, 6);
    chk("b2b second", c2, 12);
    chk("b2b Q", Q, 3);
    repeat (6) @(posedge clk);
    #1;

    // reset mid-operation
    A = 4'd14; B = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst Q", Q, 0);
    chk("midrst Rem", Rem, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midrst no done", nd, 0);
    run_op(4'd14, 4'd3, 4, 2, 0, 5, "14/3 after rst");

    // immediate start after reset release
    rst = 1'b1;
    #2;
    rst = 1'b0;
    run_op(4'd11, 4'd2, 5, 1, 0, 5, "11/2 post-rst");

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(4'(a), 4'(b), a / b, a % b, 0, 5, "sweep");
        chk("sweep identity", int'(Q) * b + int'(Rem), a);
        chk("sweep rem<b", (int'(Rem) < b) ? 1 : 0, 1);
      end
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/module_division.md
MODULE_DIVISION -- requirements
Module: module_division

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port A, input, 4 bits: dividend, unsigned.
REQ-005 SHALL have port B, input, 4 bits: divisor, unsigned.
REQ-006 SHALL have port Q, output, 4 bits: quotient, registered.
REQ-007 SHALL have port Rem, output, 4 bits: remainder, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; Q and Rem are valid from this cycle.
REQ-010 SHALL have port err, output, 1 bit: divide-by-zero flag; see Configuration.

Function
REQ-011 SHALL be a restoring divider that resolves one quotient bit per clock, MSB first.
REQ-012 SHALL use a 5-bit partial remainder P, a latched 4-bit divisor Bq, a latched dividend Aq, and a 2-bit bit index k.
REQ-013 SHALL implement the FSM states IDLE, ITER and DONE.
REQ-014 SHALL, in IDLE with start=1, latch Aq=A and Bq=B, clear P and the quotient register, set k=3, and move to ITER.
REQ-015 SHALL, in ITER, form S={P[3:0],Aq[k]} and the 5-bit difference D=S-{0,Bq}, with a sign bit equal to the borrow out.
REQ-016 SHALL, when the sign is 0, set P=D and quotient bit k to 1; otherwise set P=S and quotient bit k to 0.
REQ-017 SHALL, in ITER, decrement k; the iteration with k=0 transitions to DONE.
REQ-018 SHALL, in DONE, drive Q=quotient and Rem=P[3:0], assert done for exactly one cycle, and return to IDLE.
REQ-019 SHALL have fixed latency: with start sampled at edge n, done=1 during the cycle after edge n+5 (4 ITER cycles plus 1 DONE cycle).
REQ-020 SHALL hold busy=1 in ITER and DONE, and busy=0 in IDLE.
REQ-021 SHALL hold Q, Rem and err stable after DONE until the next accepted start.
REQ-022 SHALL ignore start while busy=1; operands changing while busy SHALL NOT affect the result.
REQ-023 SHALL accept start=1 held continuously as back-to-back operations: it is re-sampled in the IDLE cycle that follows DONE.
REQ-024 SHALL guarantee Q*B+Rem==A and Rem<B for every B≠0 (all 240 operand pairs).

Reset
REQ-025 SHALL, while rst=1, force state=IDLE and Q=0, Rem=0, busy=0, done=0, err=0, P=0 and k=0, independent of clk.
REQ-026 SHALL, on reset asserted mid-operation, abort the operation; no done pulse SHALL follow until a new start.
REQ-027 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL use the macro DIV_ZERO_CHECK_EN.
REQ-029 SHALL, when DIV_ZERO_CHECK_EN is defined and start is accepted with B=0, skip ITER and go directly to DONE with Q=4'hF, Rem=A and err=1 (done arrives 1 cycle after start); err SHALL clear on the next accepted start with B≠0.
REQ-030 SHALL, when DIV_ZERO_CHECK_EN is undefined, run B=0 through the normal 4 ITER cycles (result Q=4'hF, Rem=A) with err tied to 0.

Verification
REQ-031 SHALL cover: A=13, B=4, start pulse -> after 5 cycles done=1, Q=3, Rem=1, err=0.
REQ-032 SHALL cover: A=15, B=1 -> Q=15, Rem=0; and A=3, B=7 -> Q=0, Rem=3; and A=9, B=9 -> Q=1, Rem=0.
REQ-033 SHALL cover: A=7, B=0 -> with DIV_ZERO_CHECK_EN, done 1 cycle after start, Q=15, Rem=7, err=1; without it, done after 5 cycles, Q=15, Rem=7, err=0.
REQ-034 SHALL cover: start with A=12, B=5, then start pulses with A=1, B=1 during busy -> single done, Q=2, Rem=2.
REQ-035 SHALL cover: rst pulsed 2 cycles after start with A=14, B=3 -> all outputs 0 immediately, no done; a fresh start then gives Q=4, Rem=2.
REQ-036 SHALL cover: exhaustive sweep of A=0..15, B=1..15 -> REQ-024 holds and done arrives exactly 5 cycles after each start.
